// File: rtl/seg_mips_pkg.sv
// Shared MIPS ID-stage constants: opcodes, control bus layout and decode helpers.
package seg_mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // Bit positions inside each control bus.
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUSRC    = 2;
  localparam int EX_ALUOP_HI  = 1;
  localparam int EX_ALUOP_LO  = 0;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;
  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE:         begin c.ex = 4'b1010; c.mem = 3'b000; c.wb = 2'b10; end
      OP_LW:            begin c.ex = 4'b0100; c.mem = 3'b010; c.wb = 2'b11; end
      OP_SW:            begin c.ex = 4'b0100; c.mem = 3'b001; c.wb = 2'b00; end
      OP_BEQ:           begin c.ex = 4'b0001; c.mem = 3'b100; c.wb = 2'b00; end
      OP_ADDI, OP_LUI:  begin c.ex = 4'b0100; c.mem = 3'b000; c.wb = 2'b10; end
      OP_ANDI, OP_ORI,
      OP_XORI:          begin c.ex = 4'b0111; c.mem = 3'b000; c.wb = 2'b10; end
      default:          c = '0;
    endcase
    return c;
  endfunction

  // rt is a read operand only where the instruction consumes it as a source.
  function automatic logic rt_is_src(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/seg_id_regfile.sv
// Register file with write-through bypass; register 0 is hardwired to zero.
module seg_id_regfile
  import seg_mips_pkg::*;
#(
  parameter int LEN     = 32,
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write,
  input  logic [NB_ADDR-1:0] write_reg,
  input  logic [LEN-1:0]     write_data,
  input  logic [NB_ADDR-1:0] read_reg_1,
  input  logic [NB_ADDR-1:0] read_reg_2,
  output logic [LEN-1:0]     read_data_1,
  output logic [LEN-1:0]     read_data_2
);

  logic [LEN-1:0] regs [NB_REG];
  logic           wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB_REG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // Same-cycle write wins over the stored value so ID sees WB results immediately.
  always_comb begin
    read_data_1 = regs[read_reg_1];
    read_data_2 = regs[read_reg_2];
    if (wr_en && (write_reg == read_reg_1)) read_data_1 = write_data;
    if (wr_en && (write_reg == read_reg_2)) read_data_2 = write_data;
    if (read_reg_1 == '0) read_data_1 = '0;
    if (read_reg_2 == '0) read_data_2 = '0;
  end

endmodule

// File: rtl/seg_id_pipelined.sv
// MIPS instruction-decode stage: field/immediate/control decode, load-use hazard
// detection and the ID/EX pipeline register.
module seg_id_pipelined
  import seg_mips_pkg::*;
#(
  parameter int LEN     = 32,
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [LEN-1:0]     i_PC,
  input  logic [31:0]        i_instruc,
  input  logic               i_RegWrite,
  input  logic [NB_ADDR-1:0] i_write_reg,
  input  logic [LEN-1:0]     i_write_data,
  input  logic               i_flush,
  input  logic               i_hold,
  output logic               o_stall,
  output logic               o_valid,
  output logic [LEN-1:0]     o_PC,
  output logic [LEN-1:0]     o_read_data_1,
  output logic [LEN-1:0]     o_read_data_2,
  output logic [LEN-1:0]     o_imm_ext,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [4:0]         o_shamt,
  output logic [EX_W-1:0]    o_ctrl_ex_bus,
  output logic [MEM_W-1:0]   o_ctrl_mem_bus,
  output logic [WB_W-1:0]    o_ctrl_wb_bus
);

  typedef struct packed {
    logic               valid;
    logic [LEN-1:0]     pc;
    logic [LEN-1:0]     rd1;
    logic [LEN-1:0]     rd2;
    logic [LEN-1:0]     imm;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_ADDR-1:0] rd;
    logic [4:0]         shamt;
    ctrl_t              ctrl;
  } idex_t;

  logic [5:0]         opcode;
  logic [NB_ADDR-1:0] rs, rt, rd;
  logic [4:0]         shamt;
  logic [15:0]        imm;
  logic [LEN-1:0]     imm_ext;
  logic [LEN-1:0]     rd1, rd2;
  logic               rt_used;
  ctrl_t              ctrl;
  idex_t              idex_d, idex_q;

  assign opcode = i_instruc[31:26];
  assign rs     = NB_ADDR'(i_instruc[25:21]);
  assign rt     = NB_ADDR'(i_instruc[20:16]);
  assign rd     = NB_ADDR'(i_instruc[15:11]);
  assign shamt  = i_instruc[10:6];
  assign imm    = i_instruc[15:0];

  seg_id_regfile #(
    .LEN     (LEN),
    .NB_REG  (NB_REG),
    .NB_ADDR (NB_ADDR)
  ) u_regfile (
    .clk         (i_clk),
    .rst         (i_rst),
    .reg_write   (i_RegWrite),
    .write_reg   (i_write_reg),
    .write_data  (i_write_data),
    .read_reg_1  (rs),
    .read_reg_2  (rt),
    .read_data_1 (rd1),
    .read_data_2 (rd2)
  );

  always_comb begin
    imm_ext = LEN'($signed(imm));
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = LEN'(imm);
      OP_LUI:                   imm_ext = LEN'({imm, 16'h0000});
      default:                  imm_ext = LEN'($signed(imm));
    endcase
  end

  assign ctrl    = decode_ctrl(opcode);
  assign rt_used = rt_is_src(opcode);

  // Load in EX whose destination is read by the instruction now in ID.
  assign o_stall = idex_q.valid && idex_q.ctrl.mem[MEM_MEMREAD] && (idex_q.rt != '0) &&
                   i_valid && ((idex_q.rt == rs) || (rt_used && (idex_q.rt == rt)));

  always_comb begin
    idex_d       = '0;
    idex_d.valid = i_valid;
    idex_d.pc    = i_PC;
    idex_d.rd1   = rd1;
    idex_d.rd2   = rd2;
    idex_d.imm   = imm_ext;
    idex_d.rs    = rs;
    idex_d.rt    = rt;
    idex_d.rd    = rd;
    idex_d.shamt = shamt;
    idex_d.ctrl  = i_valid ? ctrl : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idex_q <= '0;
    end else if (i_flush) begin
      idex_q <= '0;
    end else if (i_hold) begin
      idex_q <= idex_q;
    end else if (o_stall) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign o_valid        = idex_q.valid;
  assign o_PC           = idex_q.pc;
  assign o_read_data_1  = idex_q.rd1;
  assign o_read_data_2  = idex_q.rd2;
  assign o_imm_ext      = idex_q.imm;
  assign o_rs           = idex_q.rs;
  assign o_rt           = idex_q.rt;
  assign o_rd           = idex_q.rd;
  assign o_shamt        = idex_q.shamt;
  assign o_ctrl_ex_bus  = idex_q.ctrl.ex;
  assign o_ctrl_mem_bus = idex_q.ctrl.mem;
  assign o_ctrl_wb_bus  = idex_q.ctrl.wb;

endmodule

// File: tb/tb_seg_id_pipelined.sv
// Directed bench for the ID stage: bypass, reg0, immediates, load-use, priority, reset.
module tb_seg_id_pipelined;

  localparam int LEN     = 32;
  localparam int NB_REG  = 32;
  localparam int NB_ADDR = 5;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic [LEN-1:0]     i_PC;
  logic [31:0]        i_instruc;
  logic               i_RegWrite;
  logic [NB_ADDR-1:0] i_write_reg;
  logic [LEN-1:0]     i_write_data;
  logic               i_flush;
  logic               i_hold;
  logic               o_stall;
  logic               o_valid;
  logic [LEN-1:0]     o_PC;
  logic [LEN-1:0]     o_read_data_1;
  logic [LEN-1:0]     o_read_data_2;
  logic [LEN-1:0]     o_imm_ext;
  logic [NB_ADDR-1:0] o_rs;
  logic [NB_ADDR-1:0] o_rt;
  logic [NB_ADDR-1:0] o_rd;
  logic [4:0]         o_shamt;
  logic [3:0]         o_ctrl_ex_bus;
  logic [2:0]         o_ctrl_mem_bus;
  logic [1:0]         o_ctrl_wb_bus;

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  seg_id_pipelined #(.LEN(LEN), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .i_PC           (i_PC),
    .i_instruc      (i_instruc),
    .i_RegWrite     (i_RegWrite),
    .i_write_reg    (i_write_reg),
    .i_write_data   (i_write_data),
    .i_flush        (i_flush),
    .i_hold         (i_hold),
    .o_stall        (o_stall),
    .o_valid        (o_valid),
    .o_PC           (o_PC),
    .o_read_data_1  (o_read_data_1),
    .o_read_data_2  (o_read_data_2),
    .o_imm_ext      (o_imm_ext),
    .o_rs           (o_rs),
    .o_rt           (o_rt),
    .o_rd           (o_rd),
    .o_shamt        (o_shamt),
    .o_ctrl_ex_bus  (o_ctrl_ex_bus),
    .o_ctrl_mem_bus (o_ctrl_mem_bus),
    .o_ctrl_wb_bus  (o_ctrl_wb_bus)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_PC = '0; i_instruc = '0; i_RegWrite = 1'b0;
    i_write_reg = '0; i_write_data = '0; i_flush = 1'b0; i_hold = 1'b0;
    #2;
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", o_stall); else n_pass++;
    n_total++; if ({o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus} !== 9'h000)
      $display("FAIL reset_ctrl got %h exp 000", {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus}); else n_pass++;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_bypass();
    i_RegWrite = 1'b1; i_write_reg = 5'd5; i_write_data = 32'hDEADBEEF;
    i_valid = 1'b1; i_PC = 32'h40; i_instruc = enc_r(5'd5, 5'd6, 5'd7, 5'd3, 6'h20);
    step();
    n_total++; if (o_read_data_1 !== 32'hDEADBEEF) $display("FAIL bypass_rd1 got %h exp deadbeef", o_read_data_1); else n_pass++;
    n_total++; if ({o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus} !== {4'b1010, 3'b000, 2'b10})
      $display("FAIL rtype_ctrl got %b exp 101000010", {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus}); else n_pass++;
    n_total++; if ({o_rs, o_rt, o_rd, o_shamt} !== {5'd5, 5'd6, 5'd7, 5'd3})
      $display("FAIL rtype_fields got %h exp %h", {o_rs, o_rt, o_rd, o_shamt}, {5'd5, 5'd6, 5'd7, 5'd3}); else n_pass++;
    n_total++; if (o_valid !== 1'b1 || o_PC !== 32'h40) $display("FAIL rtype_valid_pc got %b/%h exp 1/40", o_valid, o_PC); else n_pass++;
    // Stored value read through rt with no write in flight.
    i_RegWrite = 1'b0; i_PC = 32'h44; i_instruc = enc_r(5'd0, 5'd5, 5'd1, 5'd0, 6'h20);
    step();
    n_total++; if (o_read_data_2 !== 32'hDEADBEEF) $display("FAIL stored_rd2 got %h exp deadbeef", o_read_data_2); else n_pass++;
  endtask

  task automatic test_reg0();
    i_RegWrite = 1'b1; i_write_reg = 5'd0; i_write_data = 32'h1234;
    i_PC = 32'h48; i_instruc = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h20);
    step();
    n_total++; if (o_read_data_1 !== 32'h0) $display("FAIL reg0_bypass got %h exp 0", o_read_data_1); else n_pass++;
    i_RegWrite = 1'b0;
    step();
    n_total++; if (o_read_data_1 !== 32'h0) $display("FAIL reg0_stored got %h exp 0", o_read_data_1); else n_pass++;
  endtask

  task automatic test_imm();
    i_instruc = enc_i(6'h08, 5'd1, 5'd9, 16'hFFFC);
    step();
    n_total++; if (o_imm_ext !== 32'hFFFFFFFC) $display("FAIL addi_imm got %h exp fffffffc", o_imm_ext); else n_pass++;
    n_total++; if ({o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus} !== {4'b0100, 3'b000, 2'b10})
      $display("FAIL addi_ctrl got %b exp 010000010", {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus}); else n_pass++;
    i_instruc = enc_i(6'h0D, 5'd1, 5'd9, 16'hFFFC);
    step();
    n_total++; if (o_imm_ext !== 32'h0000FFFC) $display("FAIL ori_imm got %h exp 0000fffc", o_imm_ext); else n_pass++;
    n_total++; if (o_ctrl_ex_bus !== 4'b0111) $display("FAIL ori_ex got %b exp 0111", o_ctrl_ex_bus); else n_pass++;
    i_instruc = enc_i(6'h0F, 5'd0, 5'd9, 16'h1234);
    step();
    n_total++; if (o_imm_ext !== 32'h12340000) $display("FAIL lui_imm got %h exp 12340000", o_imm_ext); else n_pass++;
    n_total++; if (o_ctrl_ex_bus !== 4'b0100) $display("FAIL lui_ex got %b exp 0100", o_ctrl_ex_bus); else n_pass++;
    i_instruc = enc_i(6'h2B, 5'd1, 5'd2, 16'h8000);
    step();
    n_total++; if (o_imm_ext !== 32'hFFFF8000) $display("FAIL sw_imm got %h exp ffff8000", o_imm_ext); else n_pass++;
    n_total++; if ({o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus} !== {4'b0100, 3'b001, 2'b00})
      $display("FAIL sw_ctrl got %b exp 010000100", {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus}); else n_pass++;
    i_instruc = enc_i(6'h04, 5'd1, 5'd2, 16'h0003);
    step();
    n_total++; if ({o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus} !== {4'b0001, 3'b100, 2'b00})
      $display("FAIL beq_ctrl got %b exp 000110000", {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus}); else n_pass++;
    i_instruc = enc_i(6'h3F, 5'd1, 5'd2, 16'h0003);
    step();
    n_total++; if ({o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus} !== 9'h000 || o_valid !== 1'b1)
      $display("FAIL unknown_ctrl got %b/%b exp 000000000/1", {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus}, o_valid); else n_pass++;
    // Invalid slot: fields still flow, control is squashed.
    i_valid = 1'b0; i_PC = 32'h200; i_instruc = enc_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h20);
    step();
    n_total++; if (o_valid !== 1'b0 || o_ctrl_ex_bus !== 4'b0000 || o_PC !== 32'h200)
      $display("FAIL invalid_load got %b/%b/%h exp 0/0000/200", o_valid, o_ctrl_ex_bus, o_PC); else n_pass++;
    i_valid = 1'b1;
  endtask

  task automatic test_load_use();
    i_PC = 32'h80; i_instruc = enc_i(6'h23, 5'd0, 5'd8, 16'h0010);
    step();
    n_total++; if (o_ctrl_mem_bus !== 3'b010 || o_ctrl_wb_bus !== 2'b11)
      $display("FAIL lw_ctrl got %b/%b exp 010/11", o_ctrl_mem_bus, o_ctrl_wb_bus); else n_pass++;
    i_PC = 32'h84; i_instruc = enc_r(5'd8, 5'd0, 5'd3, 5'd0, 6'h20);
    #1;
    n_total++; if (o_stall !== 1'b1) $display("FAIL loaduse_stall got %b exp 1", o_stall); else n_pass++;
    step();
    n_total++; if (o_valid !== 1'b0 || {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus} !== 9'h000)
      $display("FAIL loaduse_bubble got %b/%b exp 0/000000000", o_valid, {o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus}); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL loaduse_stall_clear got %b exp 0", o_stall); else n_pass++;
    step();
    n_total++; if (o_valid !== 1'b1 || o_rs !== 5'd8 || o_PC !== 32'h84 || o_ctrl_ex_bus !== 4'b1010)
      $display("FAIL loaduse_enter got %b/%0d/%h/%b exp 1/8/84/1010", o_valid, o_rs, o_PC, o_ctrl_ex_bus); else n_pass++;
    // ADDI writes rt, so a matching rt must not stall.
    i_PC = 32'h88; i_instruc = enc_i(6'h23, 5'd0, 5'd8, 16'h0010);
    step();
    i_PC = 32'h8C; i_instruc = enc_i(6'h08, 5'd1, 5'd8, 16'h0001);
    #1;
    n_total++; if (o_stall !== 1'b0) $display("FAIL addi_rt_nostall got %b exp 0", o_stall); else n_pass++;
    // SW reads rt, so it must stall.
    i_instruc = enc_i(6'h2B, 5'd1, 5'd8, 16'h0004);
    #1;
    n_total++; if (o_stall !== 1'b1) $display("FAIL sw_rt_stall got %b exp 1", o_stall); else n_pass++;
    i_instruc = enc_i(6'h08, 5'd1, 5'd8, 16'h0001);
    step();
  endtask

  task automatic test_priority();
    i_PC = 32'h100; i_instruc = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    step();
    i_flush = 1'b1; i_hold = 1'b1; i_PC = 32'h104; i_instruc = enc_i(6'h08, 5'd2, 5'd4, 16'h0055);
    step();
    n_total++; if (o_valid !== 1'b0 || o_PC !== 32'h0 || o_ctrl_ex_bus !== 4'b0000 || o_rs !== 5'd0)
      $display("FAIL flush_hold_bubble got %b/%h/%b/%0d exp 0/0/0000/0", o_valid, o_PC, o_ctrl_ex_bus, o_rs); else n_pass++;
    i_flush = 1'b0; i_hold = 1'b0;
    step();
    n_total++; if (o_PC !== 32'h104 || o_imm_ext !== 32'h55) $display("FAIL reload got %h/%h exp 104/55", o_PC, o_imm_ext); else n_pass++;
    i_hold = 1'b1; i_PC = 32'h108; i_instruc = enc_i(6'h2B, 5'd6, 5'd7, 16'h0020);
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if (o_PC !== 32'h104 || o_imm_ext !== 32'h55 || o_rs !== 5'd2 || o_ctrl_ex_bus !== 4'b0100 || o_valid !== 1'b1)
        $display("FAIL hold_frozen[%0d] got %h/%h/%0d/%b/%b exp 104/55/2/0100/1", k, o_PC, o_imm_ext, o_rs, o_ctrl_ex_bus, o_valid);
      else n_pass++;
    end
    i_hold = 1'b0;
    step();
    n_total++; if (o_PC !== 32'h108) $display("FAIL hold_release got %h exp 108", o_PC); else n_pass++;
  endtask

  task automatic test_reset_mid();
    i_RegWrite = 1'b1; i_write_reg = 5'd5; i_write_data = 32'h0000_0055;
    i_PC = 32'h300; i_instruc = enc_r(5'd5, 5'd0, 5'd1, 5'd0, 6'h20);
    step();
    i_RegWrite = 1'b0;
    n_total++; if (o_read_data_1 !== 32'h55 || o_valid !== 1'b1) $display("FAIL premid got %h/%b exp 55/1", o_read_data_1, o_valid); else n_pass++;
    #2;
    i_rst = 1'b1;
    #1;
    n_total++; if (o_valid !== 1'b0 || o_PC !== 32'h0 || o_read_data_1 !== 32'h0 || o_ctrl_ex_bus !== 4'b0000)
      $display("FAIL async_reset got %b/%h/%h/%b exp 0/0/0/0000", o_valid, o_PC, o_read_data_1, o_ctrl_ex_bus); else n_pass++;
    step();
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    n_total++; if (o_read_data_1 !== 32'h0 || o_valid !== 1'b1 || o_PC !== 32'h300)
      $display("FAIL post_reset_reg5 got %h/%b/%h exp 0/1/300", o_read_data_1, o_valid, o_PC); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_reg0();
    test_imm();
    test_load_use();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
